// File: rtl/miso_pack_fifo.sv
// Multi-lane compacting-write circular FIFO with a single packed-word pop port.
// Define MISO_ERR_FLAGS_EN to add sticky o_overflow / o_underflow outputs.
module miso_pack_fifo #(
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_LENGTH = 8,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_clear,
  input  logic                              i_write_en,
  input  logic [DATA_LENGTH-1:0]            i_valid,
  input  logic [DATA_LENGTH*DATA_WIDTH-1:0] i_data,
  input  logic                              i_pop_en,
  input  logic [1:0]                        i_p_mode,
  output logic [DATA_WIDTH-1:0]             o_data,
  output logic                              o_pop_valid,
  output logic [2:0]                        o_pop_count,
  output logic                              o_wr_accept,
  output logic [CNT_WIDTH-1:0]              o_count,
  output logic                              o_empty,
  output logic                              o_full,
  output logic                              o_enough_slots
`ifdef MISO_ERR_FLAGS_EN
  ,
  output logic                              o_overflow,
  output logic                              o_underflow
`endif
);

  localparam int SUB2 = DATA_WIDTH / 2;
  localparam int SUB4 = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_w_ptr;
  logic [ADDR_WIDTH-1:0] r_r_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_pop_valid;
  logic [2:0]            r_pop_count;

  logic [CNT_WIDTH-1:0]  w_n;
  logic [CNT_WIDTH-1:0]  w_free;
  logic [ADDR_WIDTH-1:0] w_off [DATA_LENGTH];
  logic                  w_wr_accept;
  logic                  w_wr_do;
  logic                  w_pop_do;
  logic [2:0]            w_k;
  logic [2:0]            w_m;
  logic [DATA_WIDTH-1:0] w_rd [4];
  logic [DATA_WIDTH-1:0] w_pack;
  logic [CNT_WIDTH-1:0]  w_count_next;

  // Each valid lane lands after all valid lanes below it (lane-order compaction).
  always_comb begin
    w_n = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      w_off[i] = ADDR_WIDTH'(w_n);
      w_n      = w_n + CNT_WIDTH'(i_valid[i]);
    end
  end

  assign w_free      = CNT_WIDTH'(DEPTH) - r_count;
  assign w_wr_accept = i_write_en && (w_n <= w_free);
  assign w_wr_do     = w_wr_accept && !i_clear && !i_rst;
  assign w_pop_do    = i_pop_en && (r_count != '0);

  always_comb begin
    case (i_p_mode)
      2'b01:   w_k = 3'd2;
      2'b10:   w_k = 3'd4;
      default: w_k = 3'd1;
    endcase
    w_m = (r_count < CNT_WIDTH'(w_k)) ? 3'(r_count) : w_k;
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_rd[j] = r_mem[r_r_ptr + ADDR_WIDTH'(j)];
    end
  end

  always_comb begin
    w_pack = '0;
    case (w_k)
      3'd4: begin
        for (int j = 0; j < 4; j++) begin
          if (3'(j) < w_m) w_pack[j*SUB4 +: SUB4] = w_rd[j][SUB4-1:0];
        end
      end
      3'd2: begin
        for (int j = 0; j < 2; j++) begin
          if (3'(j) < w_m) w_pack[j*SUB2 +: SUB2] = w_rd[j][SUB2-1:0];
        end
      end
      default: w_pack = w_rd[0];
    endcase
  end

  // Write admission uses the cycle-start count, so slots freed by a same-cycle pop are not reused.
  assign w_count_next = r_count + (w_wr_do ? w_n : '0) - (w_pop_do ? CNT_WIDTH'(w_m) : '0);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_w_ptr     <= '0;
      r_r_ptr     <= '0;
      r_count     <= '0;
      r_data      <= '0;
      r_pop_valid <= 1'b0;
      r_pop_count <= '0;
    end else begin
      if (w_wr_do)  r_w_ptr <= r_w_ptr + ADDR_WIDTH'(w_n);
      if (w_pop_do) r_r_ptr <= r_r_ptr + ADDR_WIDTH'(w_m);
      r_count     <= w_count_next;
      r_data      <= w_pop_do ? w_pack : '0;
      r_pop_valid <= w_pop_do;
      r_pop_count <= w_pop_do ? w_m : 3'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_do) begin
      for (int i = 0; i < DATA_LENGTH; i++) begin
        if (i_valid[i]) r_mem[r_w_ptr + w_off[i]] <= i_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_data         = r_data;
  assign o_pop_valid    = r_pop_valid;
  assign o_pop_count    = r_pop_count;
  assign o_wr_accept    = w_wr_accept;
  assign o_count        = r_count;
  assign o_empty        = (r_count == '0);
  assign o_full         = (r_count == CNT_WIDTH'(DEPTH));
  assign o_enough_slots = (w_free >= CNT_WIDTH'(DATA_LENGTH));

`ifdef MISO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_write_en && !w_wr_accept) r_overflow <= 1'b1;
      if (i_pop_en && o_empty)        r_underflow <= 1'b1;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

endmodule

// File: tb/tb_miso_pack_fifo.sv
// Scoreboard bench for miso_pack_fifo: a queue model predicts admission, packing and status.
module tb_miso_pack_fifo;

  localparam int DEPTH = 32;
  localparam int DL    = 8;

  logic        r_clk = 1'b0;
  logic        r_rst = 1'b1;
  logic        r_clear = 1'b0;
  logic        r_write_en = 1'b0;
  logic [7:0]  r_valid = '0;
  logic [63:0] r_data = '0;
  logic        r_pop_en = 1'b0;
  logic [1:0]  r_mode = '0;
  logic [7:0]  w_data;
  logic        w_pop_valid;
  logic [2:0]  w_pop_count;
  logic        w_wr_accept;
  logic [5:0]  w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_enough;
`ifdef MISO_ERR_FLAGS_EN
  logic        w_overflow;
  logic        w_underflow;
  bit          exp_ovf = 0;
  bit          exp_unf = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  model_q[$];
  logic [10:0] sb_q[$];

  always #5 r_clk = ~r_clk;

  miso_pack_fifo dut (
    .i_clk          (r_clk),
    .i_rst          (r_rst),
    .i_clear        (r_clear),
    .i_write_en     (r_write_en),
    .i_valid        (r_valid),
    .i_data         (r_data),
    .i_pop_en       (r_pop_en),
    .i_p_mode       (r_mode),
    .o_data         (w_data),
    .o_pop_valid    (w_pop_valid),
    .o_pop_count    (w_pop_count),
    .o_wr_accept    (w_wr_accept),
    .o_count        (w_count),
    .o_empty        (w_empty),
    .o_full         (w_full),
    .o_enough_slots (w_enough)
`ifdef MISO_ERR_FLAGS_EN
    ,
    .o_overflow     (w_overflow),
    .o_underflow    (w_underflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs; predicts, then checks after the edge.
  task automatic step();
    int n, k, m, sz, sub;
    bit acc, popped;
    logic [7:0] w, e, mask;
    logic [10:0] ex;
    #1;
    sz  = model_q.size();
    n   = $countones(r_valid);
    acc = r_write_en && (n <= DEPTH - sz);
    chk("wr_accept", 32'(w_wr_accept), 32'(acc));
    popped = 0;
    w = '0;
    m = 0;
`ifdef MISO_ERR_FLAGS_EN
    if (r_clear) begin
      exp_ovf = 0;
      exp_unf = 0;
    end else begin
      if (r_write_en && !acc) exp_ovf = 1;
      if (r_pop_en && sz == 0) exp_unf = 1;
    end
`endif
    if (r_clear) begin
      model_q.delete();
    end else begin
      if (r_pop_en && sz > 0) begin
        k    = (r_mode == 2'b01) ? 2 : (r_mode == 2'b10) ? 4 : 1;
        sub  = 8 / k;
        mask = 8'((1 << sub) - 1);
        m    = (sz < k) ? sz : k;
        for (int j = 0; j < m; j++) begin
          e = model_q.pop_front();
          w = w | ((e & mask) << (j * sub));
        end
        popped = 1;
        sb_q.push_back({3'(m), w});
      end
      if (acc) begin
        for (int i = 0; i < DL; i++) if (r_valid[i]) model_q.push_back(r_data[i*8 +: 8]);
      end
    end
    @(posedge r_clk);
    #1;
    chk("pop_valid", 32'(w_pop_valid), 32'(popped));
    if (popped && sb_q.size() > 0) begin
      ex = sb_q.pop_front();
      chk("pop_data", 32'(w_data), 32'(ex[7:0]));
      chk("pop_count", 32'(w_pop_count), 32'(ex[10:8]));
    end else begin
      chk("idle_data", 32'(w_data), 32'd0);
      chk("idle_count", 32'(w_pop_count), 32'd0);
    end
    chk("count", 32'(w_count), 32'(model_q.size()));
    chk("empty", 32'(w_empty), 32'(model_q.size() == 0));
    chk("full", 32'(w_full), 32'(model_q.size() == DEPTH));
    chk("enough", 32'(w_enough), 32'((DEPTH - model_q.size()) >= DL));
`ifdef MISO_ERR_FLAGS_EN
    chk("overflow", 32'(w_overflow), 32'(exp_ovf));
    chk("underflow", 32'(w_underflow), 32'(exp_unf));
`endif
  endtask

  task automatic drive(input bit we, input logic [7:0] valid, input logic [7:0] base,
                       input bit pe, input logic [1:0] mode, input bit clr);
    r_write_en = we;
    r_valid    = valid;
    for (int i = 0; i < DL; i++) r_data[i*8 +: 8] = base + 8'(i);
    r_pop_en   = pe;
    r_mode     = mode;
    r_clear    = clr;
    step();
  endtask

  initial begin
    int guard;
    // T1 reset
    repeat (2) @(posedge r_clk);
    #1;
    r_rst = 1'b0;
    chk("t1_count", 32'(w_count), 32'd0);
    chk("t1_empty", 32'(w_empty), 32'd1);
    chk("t1_pop_valid", 32'(w_pop_valid), 32'd0);
    chk("t1_data", 32'(w_data), 32'd0);

    // T2 compaction
    drive(1, 8'hA5, 8'h10, 0, 2'b00, 0);
    for (int p = 0; p < 4; p++) drive(0, 8'h00, 8'h00, 1, 2'b00, 0);
    chk("t2_empty", 32'(w_empty), 32'd1);

    // T3 packing
    drive(1, 8'h07, 8'h01, 0, 2'b00, 0);
    drive(0, 8'h00, 8'h00, 1, 2'b10, 0);
    chk("t3_word", 32'(w_data), 32'h39);
    chk("t3_cnt", 32'(w_pop_count), 32'd3);

    // T4 fill, reject, wrap
    for (int b = 0; b < 4; b++) drive(1, 8'hFF, 8'(8'h20 + 8 * b), 0, 2'b00, 0);
    chk("t4_full", 32'(w_full), 32'd1);
    drive(1, 8'hFF, 8'h80, 0, 2'b00, 0);
    chk("t4_rej_count", 32'(w_count), 32'd32);
    for (int p = 0; p < 5; p++) drive(0, 8'h00, 8'h00, 1, 2'b00, 0);
    drive(1, 8'h1F, 8'hC0, 0, 2'b00, 0);
    guard = 0;
    while (model_q.size() > 0 && guard < 64) begin
      drive(0, 8'h00, 8'h00, 1, 2'(guard % 3), 0);
      guard++;
    end
    chk("t4_drained", 32'(w_empty), 32'd1);

    // T5 concurrent write/pop, then clear beats write
    drive(0, 8'h00, 8'h00, 0, 2'b00, 1);
    drive(1, 8'h0F, 8'hA0, 0, 2'b00, 0);
    drive(1, 8'hFF, 8'hB0, 1, 2'b01, 0);
    chk("t5_word", 32'(w_data), 32'h10);
    chk("t5_count", 32'(w_count), 32'd10);
    drive(1, 8'hFF, 8'hD0, 0, 2'b00, 1);
    chk("t5_clear_count", 32'(w_count), 32'd0);

    // Randomised concurrent traffic
    for (int c = 0; c < 120; c++) begin
      drive(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end

`ifdef MISO_ERR_FLAGS_EN
    // T6 sticky error flags
    drive(0, 8'h00, 8'h00, 0, 2'b00, 1);
    drive(0, 8'h00, 8'h00, 1, 2'b00, 0);
    chk("t6_unf", 32'(w_underflow), 32'd1);
    drive(0, 8'h00, 8'h00, 0, 2'b00, 0);
    chk("t6_unf_sticky", 32'(w_underflow), 32'd1);
    for (int b = 0; b < 3; b++) drive(1, 8'hFF, 8'h00, 0, 2'b00, 0);
    drive(1, 8'h0F, 8'h00, 0, 2'b00, 0);
    drive(1, 8'hFF, 8'h00, 0, 2'b00, 0);
    chk("t6_ovf", 32'(w_overflow), 32'd1);
    drive(0, 8'h00, 8'h00, 0, 2'b00, 1);
    chk("t6_clr_ovf", 32'(w_overflow), 32'd0);
    chk("t6_clr_unf", 32'(w_underflow), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
